pca_reg_write_sched: RTL and testbench
======================================

PCA_REG_WRITE_SCHED -- requirements
Module: pca_reg_write_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, write-request buffer depth (power of two, 2..16).
REQ-002 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port wr_id_i  input  8  register index from I2C target write port.
REQ-005 SHALL have port wr_value_i  input  8  register value from I2C target write port.
REQ-006 SHALL have port wr_en_i  input  1  I2C target write enable; level, may stay high many cycles.
REQ-007 SHALL have port reg_wr_id_o  output  8  register storage write index.
REQ-008 SHALL have port reg_wr_value_o  output  8  register storage write value.
REQ-009 SHALL have port reg_wr_en_o  output  1  one-cycle write strobe to register storage.
REQ-010 SHALL have port busy_o  output  1  high when FIFO non-empty or FSM not IDLE.
REQ-011 SHALL have port overflow_o  output  1  sticky flag, a request was dropped.
REQ-012 SHALL have port dbg_state_o  output  2  current FSM state encoding, for logic analyzer.

Function
REQ-013 SHALL detect a request on a 0->1 transition of wr_en_i (registered previous value); a held-high wr_en_i SHALL yield exactly one request.
REQ-014 SHALL push {wr_id_i, wr_value_i}, sampled in the detection cycle, into the FIFO at the next rising edge.
REQ-015 SHALL implement FSM states IDLE=0, ISSUE=1, EXPAND=2; code 3 unused, SHALL return to IDLE.
REQ-016 IDLE: if FIFO non-empty, pop head into a holding register and go to ISSUE; else stay.
REQ-017 ISSUE: drive head id/value with reg_wr_en_o=1 for exactly one cycle; go to EXPAND if head is an ALL_LED register (0xFA..0xFD) and expansion is enabled, else IDLE.
REQ-018 EXPAND: with k = id-0xFA and n = 0..15, issue one strobe per cycle to index 0x06+4n+k carrying the head value, 16 consecutive cycles, then IDLE.
REQ-019 Latency from detection cycle to strobe SHALL be 3 cycles with empty FIFO and FSM in IDLE; strobes SHALL follow FIFO order.
REQ-020 reg_wr_id_o/reg_wr_value_o SHALL hold their last value when reg_wr_en_o=0.
REQ-021 Push when full SHALL drop the request and set overflow_o; same-edge push and pop when full SHALL accept the push.
REQ-022 Pop when empty SHALL not occur; no strobe SHALL issue from an empty FIFO.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.
REQ-024 Index arithmetic SHALL be 8-bit; 0x06+4*15+3 = 0x45 is the maximum, no wrap.

Reset
REQ-025 On rst_ni=0 SHALL asynchronously clear: FSM to IDLE, FIFO empty, reg_wr_en_o=0, reg_wr_id_o=0, reg_wr_value_o=0, overflow_o=0, busy_o=0, edge register=0.
REQ-026 Reset during EXPAND SHALL abort remaining strobes; no strobe SHALL follow reset release until a new request.
REQ-027 wr_en_i high at reset release SHALL NOT count as a request until it falls and rises again.

Configuration
REQ-028 Macro PCA_ALL_LED_EXPAND_EN defined: REQ-018 behaviour compiled in.
REQ-029 Macro PCA_ALL_LED_EXPAND_EN undefined: EXPAND state and counter absent; ALL_LED writes issue a single strobe only; dbg_state_o never reads 2.

Structure
REQ-030 Register indices (LED0_ON_L=0x06, ALL_LED_ON_L=0xFA..ALL_LED_OFF_H=0xFD) and FSM state encodings SHALL live in the shared PCA register package/include.
REQ-031 FIFO SHALL be a sub-module pca_wr_fifo (parameter DEPTH, 16-bit data, push/pop/full/empty).

Verification
REQ-032 Single write 0x00=0x21, wr_en_i held 10 cycles -> exactly one strobe id 0x00 val 0x21, 3 cycles after rising edge.
REQ-033 With macro: write 0xFC=0x80 -> strobe 0xFC/0x80 then 16 strobes 0x08,0x0C,...,0x44 all value 0x80, consecutive cycles, busy_o low after.
REQ-034 Without macro: write 0xFC=0x80 -> single strobe 0xFC/0x80, no further strobes.
REQ-035 During expansion push 5 requests (DEPTH=4) -> first 4 issued in order after expansion, 5th dropped, overflow_o=1 until reset.
REQ-036 Assert rst_ni=0 at 5th expansion strobe -> outputs zero immediately, no further strobes after release, overflow_o=0.
REQ-037 wr_en_i high across reset release -> no strobe until wr_en_i toggles 0->1.

Source files
------------

// File: rtl/pca_reg_write_sched_pkg.sv
// Shared PCA register indices and write-scheduler FSM encodings.
package pca_reg_write_sched_pkg;

  localparam logic [7:0] LED0_ON_L     = 8'h06;
  localparam logic [7:0] ALL_LED_ON_L  = 8'hFA;
  localparam logic [7:0] ALL_LED_OFF_H = 8'hFD;
  localparam int         FIFO_DATA_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  function automatic logic is_all_led(input logic [7:0] id);
    return (id >= ALL_LED_ON_L) && (id <= ALL_LED_OFF_H);
  endfunction

endpackage

// File: rtl/pca_reg_write_sched_if.sv
// Push/pop bus between the write scheduler (master) and its request FIFO (slave).
interface pca_reg_write_sched_if;
  import pca_reg_write_sched_pkg::*;

  logic                   push;
  logic [FIFO_DATA_W-1:0] push_data;
  logic                   pop;
  logic [FIFO_DATA_W-1:0] pop_data;
  logic                   full;
  logic                   empty;

  modport master (output push, push_data, pop, input pop_data, full, empty);
  modport slave  (input push, push_data, pop, output pop_data, full, empty);
endinterface

// File: rtl/pca_wr_fifo.sv
// Write-request FIFO; an extra pointer bit separates full from empty, and a
// push into a full FIFO is accepted when a pop happens on the same edge.
module pca_wr_fifo
  import pca_reg_write_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pca_reg_write_sched_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [FIFO_DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]            wr_ptr_q, rd_ptr_q;
  logic                   do_push, do_pop;

  assign bus.empty    = (wr_ptr_q == rd_ptr_q);
  assign bus.full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop       = bus.pop & ~bus.empty;
  assign do_push      = bus.push & (~bus.full | do_pop);
  assign bus.pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= bus.push_data;
  end

endmodule

// File: rtl/pca_reg_write_sched.sv
// Schedules I2C register writes into register storage, one strobe per cycle.
// Define PCA_ALL_LED_EXPAND_EN to fan ALL_LED writes out to all 16 LED channels.
module pca_reg_write_sched
  import pca_reg_write_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] wr_id_i,
  input  logic [7:0] wr_value_i,
  input  logic       wr_en_i,
  output logic [7:0] reg_wr_id_o,
  output logic [7:0] reg_wr_value_o,
  output logic       reg_wr_en_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic [1:0] dbg_state_o
);

  pca_reg_write_sched_if fifo_bus ();

  pca_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (fifo_bus.slave)
  );

  logic        wr_en_prev_q, armed_q, req, pop;
  state_e      state_q, state_d;
  logic [15:0] head_q, head_d;
  logic [7:0]  id_q, id_d, val_q, val_d;
  logic        en_q, en_d, overflow_q;
`ifdef PCA_ALL_LED_EXPAND_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  // armed_q stays low until wr_en_i has been seen low, so a level held across
  // reset release is not mistaken for a fresh request.
  assign req = wr_en_i & ~wr_en_prev_q & armed_q;

  assign fifo_bus.push      = req;
  assign fifo_bus.push_data = {wr_id_i, wr_value_i};
  assign fifo_bus.pop       = pop;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    pop     = 1'b0;
    en_d    = 1'b0;
    id_d    = id_q;
    val_d   = val_q;
`ifdef PCA_ALL_LED_EXPAND_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_bus.empty) begin
          pop     = 1'b1;
          head_d  = fifo_bus.pop_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        en_d    = 1'b1;
        id_d    = head_q[15:8];
        val_d   = head_q[7:0];
        state_d = ST_IDLE;
`ifdef PCA_ALL_LED_EXPAND_EN
        if (is_all_led(head_q[15:8])) begin
          state_d = ST_EXPAND;
          cnt_d   = 4'd0;
        end
`endif
      end
`ifdef PCA_ALL_LED_EXPAND_EN
      ST_EXPAND: begin
        en_d  = 1'b1;
        id_d  = LED0_ON_L + {2'b00, cnt_q, 2'b00} + (head_q[15:8] - ALL_LED_ON_L);
        val_d = head_q[7:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      head_q       <= '0;
      id_q         <= '0;
      val_q        <= '0;
      en_q         <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef PCA_ALL_LED_EXPAND_EN
      cnt_q        <= '0;
`endif
    end else begin
      wr_en_prev_q <= wr_en_i;
      armed_q      <= armed_q | ~wr_en_i;
      state_q      <= state_d;
      head_q       <= head_d;
      id_q         <= id_d;
      val_q        <= val_d;
      en_q         <= en_d;
      overflow_q   <= overflow_q | (req & fifo_bus.full & ~pop);
`ifdef PCA_ALL_LED_EXPAND_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign reg_wr_id_o    = id_q;
  assign reg_wr_value_o = val_q;
  assign reg_wr_en_o    = en_q;
  assign overflow_o     = overflow_q;
  assign busy_o         = ~fifo_bus.empty | (state_q != ST_IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pca_reg_write_sched.sv
// Directed bench for pca_reg_write_sched and its request FIFO.
module tb_pca_reg_write_sched;
  import pca_reg_write_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_id = 8'h00, wr_value = 8'h00;
  logic       wr_en = 1'b0;
  logic [7:0] reg_wr_id, reg_wr_value;
  logic       reg_wr_en, busy, overflow;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int det;
  bit saw_expand = 1'b0;

  int         s_cyc[$];
  logic [7:0] s_id[$];
  logic [7:0] s_val[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin
      s_cyc.push_back(cyc);
      s_id.push_back(reg_wr_id);
      s_val.push_back(reg_wr_value);
    end
    if (dbg_state == 2'd2) saw_expand = 1'b1;
  end

  pca_reg_write_sched #(.FIFO_DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wr_id_i        (wr_id),
    .wr_value_i     (wr_value),
    .wr_en_i        (wr_en),
    .reg_wr_id_o    (reg_wr_id),
    .reg_wr_value_o (reg_wr_value),
    .reg_wr_en_o    (reg_wr_en),
    .busy_o         (busy),
    .overflow_o     (overflow),
    .dbg_state_o    (dbg_state)
  );

  pca_reg_write_sched_if fbus ();
  pca_wr_fifo #(.DEPTH(4)) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (fbus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    s_cyc.delete();
    s_id.delete();
    s_val.delete();
  endtask

  task automatic pulse(input logic [7:0] id, input logic [7:0] val, output int d);
    wr_id    = id;
    wr_value = val;
    wr_en    = 1'b1;
    d        = cyc;
    step(1);
    wr_en    = 1'b0;
    step(1);
  endtask

  initial begin
    int d2;
    fbus.push      = 1'b0;
    fbus.pop       = 1'b0;
    fbus.push_data = '0;
    step(3);
    chk("rst_en",       reg_wr_en, 1'b0);
    chk("rst_id",       reg_wr_id, 8'h00);
    chk("rst_val",      reg_wr_value, 8'h00);
    chk("rst_busy",     busy, 1'b0);
    chk("rst_ovf",      overflow, 1'b0);
    chk("rst_state",    dbg_state, 2'd0);
    chk("rst_fifo_emp", fbus.empty, 1'b1);
    rst_n = 1'b1;
    step(2);

    // Standalone FIFO: fill, push+pop while full, drain in order
    for (int i = 0; i < 4; i++) begin
      fbus.push = 1'b1;
      fbus.push_data = 16'h1100 + 16'(i);
      step(1);
    end
    fbus.push = 1'b0;
    chk("fifo_full",  fbus.full, 1'b1);
    chk("fifo_head",  fbus.pop_data, 16'h1100);
    fbus.push = 1'b1;
    fbus.pop  = 1'b1;
    fbus.push_data = 16'h1104;
    step(1);
    fbus.push = 1'b0;
    fbus.pop  = 1'b0;
    chk("fifo_full_pushpop", fbus.full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", fbus.pop_data, 16'h1101 + 16'(i));
      fbus.pop = 1'b1;
      step(1);
      fbus.pop = 1'b0;
    end
    chk("fifo_empty", fbus.empty, 1'b1);

    // Single write with wr_en held high for 10 cycles
    clear_log();
    wr_id = 8'h00; wr_value = 8'h21; wr_en = 1'b1;
    det = cyc;
    step(10);
    wr_en = 1'b0;
    step(6);
    chk("single_cnt", s_id.size(), 1);
    if (s_id.size() >= 1) begin
      chk("single_id",  s_id[0], 8'h00);
      chk("single_val", s_val[0], 8'h21);
      chk("single_lat", s_cyc[0] - det, 3);
    end
    chk("hold_id",  reg_wr_id, 8'h00);
    chk("hold_val", reg_wr_value, 8'h21);
    chk("idle_busy", busy, 1'b0);

    // ALL_LED write 0xFC = 0x80
    clear_log();
    pulse(8'hFC, 8'h80, det);
    step(25);
`ifdef PCA_ALL_LED_EXPAND_EN
    chk("exp_cnt", s_id.size(), 17);
    if (s_id.size() == 17) begin
      chk("exp_head_id",  s_id[0], 8'hFC);
      chk("exp_head_val", s_val[0], 8'h80);
      chk("exp_head_lat", s_cyc[0] - det, 3);
      for (int n = 0; n < 16; n++) begin
        chk("exp_id",  s_id[n+1], 8'h08 + 8'(4*n));
        chk("exp_val", s_val[n+1], 8'h80);
        chk("exp_cyc", s_cyc[n+1] - det, 4 + n);
      end
    end
    chk("exp_seen_state2", saw_expand, 1'b1);
`else
    chk("noexp_cnt", s_id.size(), 1);
    if (s_id.size() >= 1) begin
      chk("noexp_id",  s_id[0], 8'hFC);
      chk("noexp_val", s_val[0], 8'h80);
    end
    chk("noexp_no_state2", saw_expand, 1'b0);
`endif
    chk("exp_busy_after", busy, 1'b0);

    // Five requests issued back to back behind an ALL_LED write
    clear_log();
    pulse(8'hFA, 8'h11, det);
    for (int i = 0; i < 5; i++) pulse(8'h10 + 8'(i), 8'hB0 + 8'(i), d2);
    step(30);
`ifdef PCA_ALL_LED_EXPAND_EN
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_cnt", s_id.size(), 21);
    if (s_id.size() == 21) begin
      chk("ovf_exp_first", s_id[1], 8'h06);
      chk("ovf_exp_last",  s_id[16], 8'h42);
      for (int i = 0; i < 4; i++) begin
        chk("ovf_order_id",  s_id[17+i], 8'h10 + 8'(i));
        chk("ovf_order_val", s_val[17+i], 8'hB0 + 8'(i));
      end
    end
    step(5);
    chk("ovf_sticky", overflow, 1'b1);
`else
    chk("noovf_flag", overflow, 1'b0);
    chk("noovf_cnt", s_id.size(), 6);
    if (s_id.size() == 6) begin
      for (int i = 0; i < 5; i++) chk("noovf_order", s_id[1+i], 8'h10 + 8'(i));
    end
`endif

    // Reset asserted during the 5th expansion strobe
    clear_log();
    pulse(8'hFD, 8'h55, det);
    step(6);
`ifdef PCA_ALL_LED_EXPAND_EN
    chk("mid_en",  reg_wr_en, 1'b1);
    chk("mid_id",  reg_wr_id, 8'h19);
`else
    chk("mid_en",  reg_wr_en, 1'b0);
`endif
    rst_n = 1'b0;
    #1;
    chk("arst_en",    reg_wr_en, 1'b0);
    chk("arst_id",    reg_wr_id, 8'h00);
    chk("arst_val",   reg_wr_value, 8'h00);
    chk("arst_ovf",   overflow, 1'b0);
    chk("arst_busy",  busy, 1'b0);
    chk("arst_state", dbg_state, 2'd0);
    step(2);
    rst_n = 1'b1;
    step(25);
`ifdef PCA_ALL_LED_EXPAND_EN
    chk("arst_no_more", s_id.size(), 5);
`else
    chk("arst_no_more", s_id.size(), 1);
`endif

    // wr_en held high across reset release
    rst_n = 1'b0;
    wr_id = 8'h33; wr_value = 8'h44; wr_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    clear_log();
    step(10);
    chk("held_no_strobe", s_id.size(), 0);
    chk("held_busy", busy, 1'b0);
    wr_en = 1'b0;
    step(1);
    wr_en = 1'b1;
    det = cyc;
    step(2);
    wr_en = 1'b0;
    step(6);
    chk("retoggle_cnt", s_id.size(), 1);
    if (s_id.size() >= 1) begin
      chk("retoggle_id",  s_id[0], 8'h33);
      chk("retoggle_val", s_val[0], 8'h44);
      chk("retoggle_lat", s_cyc[0] - det, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
